alu_share_arb: RTL and testbench

Round-robin arbiter and sequencer sharing the single registered ALU between up to four requesters, e.g. the main execute stage, a branch-compare unit and an address-generation unit. It accepts operations with a valid/ready handshake and drives the ALU operand and control inputs from a register stage. It tracks each issued operation through the ALU's one-cycle result register and returns the result to the issuing requester, tagged and with an error flag.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/rr_arb.sv | 56 +++++
 rtl/alu_share_arb.sv | 148 ++++++++++++++
 tb/tb_alu_share_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for every block that drives the single registered ALU.
//   - ALU control codes
//   - alu_code_ok(): whether the ALU implements a code
//   - ALU_LAT: register stages inside the ALU
//   - RSP_LAT: request-to-response latency of the sharing arbiter
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;  // unsigned compare
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam int ALU_LAT = 1;
  // One issue register, the ALU stages, and one response register.
  localparam int RSP_LAT = ALU_LAT + 2;

  // The ALU returns 0 for anything not listed here.
  function automatic logic alu_code_ok(input logic [3:0] code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin arbiter with a registered priority pointer.
//   clk, rst  : clock, synchronous active-high reset (pointer returns to 0)
//   req[N]    : request vector
//   gnt[N]    : one-hot grant (all zero when nothing requests), combinational
//   gnt_any   : some bit of gnt is high
//   gnt_idx   : index of the granted port, meaningful only with gnt_any
// The search starts at the pointer and wraps; after a grant to port k the
// pointer moves to k+1 (mod N). Without a grant the pointer holds.
module rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_any,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;

  always_comb begin : search
    int            idx;
    logic [IW-1:0] sel;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!gnt_any && req[sel]) begin
        gnt_any  = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_any) begin
      ptr_next = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one registered ALU between NREQ requesters.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : per-port handshake; ready is the round-robin grant
//   req_in1/in2 [NREQ*32]  : operands, port k at [32k+31:32k]
//   req_ctrl    [NREQ*4]   : ALU code, port k at [4k+3:4k]
//   alu_in1/in2/ctrl       : registered ALU inputs (loaded on a grant, else held)
//   alu_out                : ALU result register output (one cycle after alu_*)
//   rsp_valid [NREQ]       : one-cycle result pulse for the issuing port
//   rsp_data, rsp_err      : result (0 for unsupported codes) and error flag
// Handshake in cycle N -> alu_* in N+1 -> alu_out in N+2 -> response in N+3.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_in1,
  input  logic [NREQ*32-1:0] req_in2,
  input  logic [NREQ*4-1:0]  req_ctrl,
  output logic [31:0]       alu_in1,
  output logic [31:0]       alu_in2,
  output logic [3:0]        alu_ctrl,
  input  logic [31:0]       alu_out,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Tracking stages: s1 (aligned with alu_*) then one per ALU register, so
  // the last stage lines up with alu_out.
  localparam int NSTG = 1 + ALU_LAT;

  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [TW-1:0]   gnt_idx;

  rr_arb #(
    .N  (NREQ),
    .IW (TW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;

  // Per-port views of the flattened request buses.
  logic [31:0] in1_arr  [NREQ];
  logic [31:0] in2_arr  [NREQ];
  logic [3:0]  ctrl_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_port
      assign in1_arr[gi]  = req_in1[32*gi +: 32];
      assign in2_arr[gi]  = req_in2[32*gi +: 32];
      assign ctrl_arr[gi] = req_ctrl[4*gi +: 4];
    end
  endgenerate

  // Issue register: only loaded on a grant so the ALU inputs stay quiet
  // while idle.
  logic [31:0] alu_in1_reg;
  logic [31:0] alu_in2_reg;
  logic [3:0]  alu_ctrl_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in1_reg  <= '0;
      alu_in2_reg  <= '0;
      alu_ctrl_reg <= 4'b0000;
    end else if (gnt_any) begin
      alu_in1_reg  <= in1_arr[gnt_idx];
      alu_in2_reg  <= in2_arr[gnt_idx];
      alu_ctrl_reg <= ctrl_arr[gnt_idx];
    end
  end

  assign alu_in1  = alu_in1_reg;
  assign alu_in2  = alu_in2_reg;
  assign alu_ctrl = alu_ctrl_reg;

  // Tag pipeline travelling alongside the ALU.
  logic [NSTG-1:0] stg_valid_reg;
  logic [NSTG-1:0] stg_err_reg;
  logic [TW-1:0]   stg_tag_reg [NSTG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSTG; i++) begin
        stg_valid_reg[i] <= 1'b0;
        stg_err_reg[i]   <= 1'b0;
        stg_tag_reg[i]   <= '0;
      end
    end else begin
      stg_valid_reg[0] <= gnt_any;
      stg_err_reg[0]   <= gnt_any & ~alu_code_ok(ctrl_arr[gnt_idx]);
      stg_tag_reg[0]   <= gnt_idx;
      for (int i = 1; i < NSTG; i++) begin
        stg_valid_reg[i] <= stg_valid_reg[i-1];
        stg_err_reg[i]   <= stg_err_reg[i-1];
        stg_tag_reg[i]   <= stg_tag_reg[i-1];
      end
    end
  end

  // Response register.
  logic [NREQ-1:0] rsp_valid_reg, rsp_valid_next;
  logic [31:0]     rsp_data_reg,  rsp_data_next;
  logic            rsp_err_reg,   rsp_err_next;

  always_comb begin
    rsp_valid_next = '0;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = 1'b0;
    if (stg_valid_reg[NSTG-1]) begin
      rsp_valid_next[stg_tag_reg[NSTG-1]] = 1'b1;
      rsp_err_next  = stg_err_reg[NSTG-1];
      // Force zero on bad codes rather than trusting the ALU's default.
      rsp_data_next = stg_err_reg[NSTG-1] ? 32'd0 : alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a 2-port instance for the main sequence
// and a 4-port instance for the pointer wrap case. Each instance drives its
// own registered ALU model.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- 2-port instance ----------------
  logic [1:0]  rv2;
  logic [1:0]  ready2;
  logic [63:0] in1_2, in2_2;
  logic [7:0]  ctrl2;
  logic [31:0] ai1_2, ai2_2, aout2, rspd2;
  logic [3:0]  actrl2;
  logic [1:0]  rspv2;
  logic        rspe2;

  alu_share_arb #(.NREQ(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv2),
    .req_ready (ready2),
    .req_in1   (in1_2),
    .req_in2   (in2_2),
    .req_ctrl  (ctrl2),
    .alu_in1   (ai1_2),
    .alu_in2   (ai2_2),
    .alu_ctrl  (actrl2),
    .alu_out   (aout2),
    .rsp_valid (rspv2),
    .rsp_data  (rspd2),
    .rsp_err   (rspe2)
  );

  // ---------------- 4-port instance ----------------
  logic [3:0]   rv4;
  logic [3:0]   ready4;
  logic [127:0] in1_4, in2_4;
  logic [15:0]  ctrl4;
  logic [31:0]  ai1_4, ai2_4, aout4, rspd4;
  logic [3:0]   actrl4;
  logic [3:0]   rspv4;
  logic         rspe4;

  alu_share_arb #(.NREQ(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv4),
    .req_ready (ready4),
    .req_in1   (in1_4),
    .req_in2   (in2_4),
    .req_ctrl  (ctrl4),
    .alu_in1   (ai1_4),
    .alu_in2   (ai2_4),
    .alu_ctrl  (actrl4),
    .alu_out   (aout4),
    .rsp_valid (rspv4),
    .rsp_data  (rspd4),
    .rsp_err   (rspe4)
  );

  // External registered ALU: unsupported codes give 0.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {31'd0, (a < b)};
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    aout2 <= alu_f(ai1_2, ai2_2, actrl2);
    aout4 <= alu_f(ai1_4, ai2_4, actrl4);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle on the 2-port instance: drive valids, check ready and the
  // response visible in this cycle, then advance to the next cycle.
  task automatic cyc2(input string tag, input logic [1:0] rv, input logic [1:0] rdy_exp,
                      input logic [1:0] rspv_exp, input logic [31:0] data_exp,
                      input logic err_exp);
    rv2 = rv;
    #1;
    $display("%s: valid=%b ready=%b rsp_valid=%b rsp_data=%h rsp_err=%b",
             tag, rv, ready2, rspv2, rspd2, rspe2);
    chk({tag, ".ready"}, 32'(ready2), 32'(rdy_exp));
    chk({tag, ".rsp_valid"}, 32'(rspv2), 32'(rspv_exp));
    if (rspv_exp != 2'b00) begin
      chk({tag, ".rsp_data"}, rspd2, data_exp);
      chk({tag, ".rsp_err"}, 32'(rspe2), 32'(err_exp));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input string tag, input logic [3:0] rv, input logic [3:0] rdy_exp,
                      input logic [3:0] rspv_exp, input logic [31:0] data_exp);
    rv4 = rv;
    #1;
    $display("%s: valid=%b ready=%b rsp_valid=%b rsp_data=%h rsp_err=%b",
             tag, rv, ready4, rspv4, rspd4, rspe4);
    chk({tag, ".ready"}, 32'(ready4), 32'(rdy_exp));
    chk({tag, ".rsp_valid"}, 32'(rspv4), 32'(rspv_exp));
    if (rspv_exp != 4'b0000) begin
      chk({tag, ".rsp_data"}, rspd4, data_exp);
      chk({tag, ".rsp_err"}, 32'(rspe4), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  w_rv   [6];
  logic [3:0]  w_rdy  [6];
  logic [3:0]  w_rspv [6];
  logic [31:0] w_data [6];

  initial begin
    logic [1:0]  rv, rdy, rspv;
    logic [31:0] dexp;

    rst   = 1'b1;
    rv2   = '0; in1_2 = '0; in2_2 = '0; ctrl2 = '0;
    rv4   = '0; in1_4 = '0; in2_4 = '0; ctrl4 = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    chk("reset.alu_in1",   ai1_2, 32'd0);
    chk("reset.alu_in2",   ai2_2, 32'd0);
    chk("reset.alu_ctrl",  32'(actrl2), 32'd0);
    chk("reset.rsp_valid", 32'(rspv2), 32'd0);
    chk("reset.rsp_data",  rspd2, 32'd0);
    chk("reset.rsp_err",   32'(rspe2), 32'd0);
    chk("reset.rsp_valid4", 32'(rspv4), 32'd0);
    rst = 1'b0;

    // Single ADD on port 0: 5 + 7.
    in1_2[31:0] = 32'd5; in2_2[31:0] = 32'd7; ctrl2[3:0] = 4'b0010;
    cyc2("add.c0", 2'b01, 2'b01, 2'b00, 32'd0, 1'b0);
    chk("add.alu_in1",  ai1_2, 32'd5);
    chk("add.alu_in2",  ai2_2, 32'd7);
    chk("add.alu_ctrl", 32'(actrl2), 32'd2);
    in1_2[31:0] = 32'd99;  // post-handshake change must not matter
    cyc2("add.c1", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);
    cyc2("add.c2", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);
    cyc2("add.c3", 2'b00, 2'b00, 2'b01, 32'd12, 1'b0);
    cyc2("add.c4", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);

    // Unsupported code on port 0.
    in1_2[31:0] = 32'h1234; in2_2[31:0] = 32'h55; ctrl2[3:0] = 4'b1010;
    cyc2("bad.c0", 2'b01, 2'b01, 2'b00, 32'd0, 1'b0);
    chk("bad.alu_ctrl", 32'(actrl2), 32'hA);
    cyc2("bad.c1", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);
    cyc2("bad.c2", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);
    cyc2("bad.c3", 2'b00, 2'b00, 2'b01, 32'd0, 1'b1);
    cyc2("bad.c4", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);

    // Back-to-back AND on port 1 for three cycles.
    in1_2[63:32] = 32'hF0F0_F0F0; in2_2[63:32] = 32'hFF00_FF00; ctrl2[7:4] = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      rv   = (i < 3) ? 2'b10 : 2'b00;
      rspv = (i >= 3 && i < 6) ? 2'b10 : 2'b00;
      cyc2($sformatf("b2b.c%0d", i), rv, rv, rspv, 32'hF000_F000, 1'b0);
    end

    // Contention: port 0 SUB 3-5, port 1 SLT 3<5, both valid for 4 cycles.
    in1_2 = {32'd3, 32'd3}; in2_2 = {32'd5, 32'd5}; ctrl2 = {4'b0111, 4'b0110};
    for (int i = 0; i < 8; i++) begin
      rv   = (i < 4) ? 2'b11 : 2'b00;
      rdy  = (i < 4) ? ((i % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      rspv = (i >= 3 && i < 7) ? (((i - 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      dexp = (rspv == 2'b10) ? 32'd1 : 32'hFFFF_FFFE;
      cyc2($sformatf("cont.c%0d", i), rv, rdy, rspv, dexp, 1'b0);
    end

    // Reset mid-flight: grant port 1 then port 0 (pointer -> 1), then reset.
    in1_2 = {32'd10, 32'd1}; in2_2 = {32'd20, 32'd2}; ctrl2 = 8'h22;
    cyc2("rst.a", 2'b10, 2'b10, 2'b00, 32'd0, 1'b0);
    cyc2("rst.b", 2'b01, 2'b01, 2'b00, 32'd0, 1'b0);
    rst = 1'b1;
    cyc2("rst.c", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);
    rst = 1'b0;
    chk("rst.alu_in1",  ai1_2, 32'd0);
    chk("rst.alu_in2",  ai2_2, 32'd0);
    chk("rst.alu_ctrl", 32'(actrl2), 32'd0);
    chk("rst.rsp_data", rspd2, 32'd0);
    chk("rst.rsp_err",  32'(rspe2), 32'd0);
    cyc2("rst.d", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);
    cyc2("rst.e", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);
    cyc2("rst.f", 2'b11, 2'b01, 2'b00, 32'd0, 1'b0);
    cyc2("rst.g", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);
    cyc2("rst.h", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);
    cyc2("rst.i", 2'b00, 2'b00, 2'b01, 32'd3, 1'b0);
    cyc2("rst.j", 2'b00, 2'b00, 2'b00, 32'd0, 1'b0);

    // NREQ=4 wrap: port 1 OR 0x0F|0xF0, port 3 NOR 0,0.
    in1_4[63:32] = 32'h0F; in2_4[63:32] = 32'hF0; ctrl4[7:4] = 4'b0001;
    in1_4[127:96] = 32'd0; in2_4[127:96] = 32'd0; ctrl4[15:12] = 4'b1100;
    w_rv   = '{4'b1000, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
    w_rdy  = '{4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    w_rspv = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b1000};
    w_data = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      cyc4($sformatf("wrap.c%0d", i), w_rv[i], w_rdy[i], w_rspv[i], w_data[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
